stim_player: RTL and testbench

- Stimulus pattern generator that drives sample vectors *into* the FFT datapath. It is the write/drive counterpart of the on-chip analyzer, which only observes `sum` and `xk_re`/`xk_im`.
- A host or loader writes a pattern RAM; `start_i` then replays it one sample per pacing strobe, optionally looping.
- `trig_o` marks each pass start so the analyzer trigger can align to it. The block sits between the ADC front end (as a selectable alternate source) and `fft_inst`.

---
 rtl/stim_player.sv | 150 +++++++++++++++
 tb/tb_stim_player.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stim_player.sv
`default_nettype none
// ============================================================================
//  Module   : stim_player
//  Purpose  : Pattern-RAM stimulus generator that replays loaded samples into
//             the FFT datapath, one sample per pacing strobe, with optional loop.
//  Revision : 1.0  initial release
// ============================================================================
module stim_player #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              loop_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              sample_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              trig_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        pass_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              done_q, done_d;
    logic [7:0]        pass_q, pass_d;
    logic              last_w;

    // No reset on the pattern RAM: contents survive reset and abort.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign last_w = ({1'b0, idx_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        done_d  = 1'b0;
        pass_d  = pass_q;

        if (abort_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        state_d = ST_PLAY;
                        len_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
                        idx_d   = '0;
                        pass_d  = '0;
                    end
                end
                ST_PLAY: begin
                    if (sample_en_i) begin
                        data_d  = mem_q[idx_q];
                        valid_d = 1'b1;
                        sop_d   = (idx_q == '0);
                        eop_d   = last_w;
                        if (last_w) begin
                            idx_d = '0;
                            if (pass_q != 8'hFF) begin
                                pass_d = pass_q + 8'd1;
                            end
                            if (!loop_i) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign sop_o      = sop_q;
    assign trig_o     = sop_q;
    assign eop_o      = eop_q;
    assign done_o     = done_q;
    assign pass_cnt_o = pass_q;
    // The final (done) sample still counts as busy; busy falls the cycle after.
    assign busy_o     = (state_q == ST_PLAY) || done_q;

endmodule
`default_nettype wire

// File: tb/tb_stim_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stim_player
//  Purpose  : Directed self-checking bench for stim_player.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stim_player;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic [ADDR_W:0]   len_i;
    logic              loop_i;
    logic              start_i;
    logic              abort_i;
    logic              sample_en_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              sop_o;
    logic              eop_o;
    logic              trig_o;
    logic              busy_o;
    logic              done_o;
    logic [7:0]        pass_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_mem [DEPTH];

    stim_player #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .len_i       (len_i),
        .loop_i      (loop_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .sample_en_i (sample_en_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .trig_o      (trig_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_cnt_o  (pass_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        wr_en_i   = 1'b1;
        wr_addr_i = ADDR_W'(addr);
        wr_data_i = DATA_W'(data);
        tick();
        wr_en_i   = 1'b0;
        exp_mem[addr] = DATA_W'(data);
    endtask

    task automatic start_run(input int len, input bit lp);
        len_i   = (ADDR_W+1)'(len);
        loop_i  = lp;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Consume one strobe at index idx and check the sample it produces.
    task automatic do_strobe(input int idx, input int len, input bit fin, input int pass);
        sample_en_i = 1'b1;
        tick();
        check_val("valid", 32'(valid_o), 32'(1));
        check_val("data",  32'(data_o),  32'(exp_mem[idx]));
        check_val("sop",   32'(sop_o),   32'(idx == 0));
        check_val("trig",  32'(trig_o),  32'(idx == 0));
        check_val("eop",   32'(eop_o),   32'(idx == len - 1));
        check_val("done",  32'(done_o),  32'(fin));
        check_val("pass",  32'(pass_cnt_o), 32'(pass));
    endtask

    initial begin
        int passes;
        rst_n_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        len_i = '0; loop_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; sample_en_i = 1'b0;
        tick(); tick();
        check_val("rst_data",  32'(data_o),     32'(0));
        check_val("rst_valid", 32'(valid_o),    32'(0));
        check_val("rst_busy",  32'(busy_o),     32'(0));
        check_val("rst_done",  32'(done_o),     32'(0));
        check_val("rst_pass",  32'(pass_cnt_o), 32'(0));
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) wr(i, i + 16);

        // Single pass, strobe every 4 cycles
        start_run(8, 1'b0);
        check_val("a_busy_start", 32'(busy_o), 32'(1));
        for (int k = 0; k < 8; k++) begin
            repeat (3) tick();
            check_val("a_gap_valid", 32'(valid_o), 32'(0));
            if (k > 0) check_val("a_gap_hold", 32'(data_o), 32'(exp_mem[k-1]));
            do_strobe(k, 8, k == 7, (k == 7) ? 1 : 0);
            sample_en_i = 1'b0;
        end
        check_val("a_busy_done", 32'(busy_o), 32'(1));
        tick();
        check_val("a_busy_after", 32'(busy_o),     32'(0));
        check_val("a_done_after", 32'(done_o),     32'(0));
        check_val("a_pass_after", 32'(pass_cnt_o), 32'(1));
        check_val("a_hold_after", 32'(data_o),     32'(8'h17));

        // Looping len 3, continuous strobe, loop dropped mid-pass
        start_run(3, 1'b1);
        passes = 0;
        for (int k = 0; k < 7; k++) begin
            if (k % 3 == 2) passes++;
            do_strobe(k % 3, 3, 1'b0, passes);
        end
        loop_i = 1'b0;
        do_strobe(1, 3, 1'b0, 2);
        do_strobe(2, 3, 1'b1, 3);
        sample_en_i = 1'b0;
        tick();
        check_val("b_busy_after", 32'(busy_o), 32'(0));
        check_val("b_pass_after", 32'(pass_cnt_o), 32'(3));

        // len 0 ignored; len 100 clamps to 64
        start_run(0, 1'b0);
        check_val("c_len0_busy", 32'(busy_o), 32'(0));
        tick();
        check_val("c_len0_busy2", 32'(busy_o), 32'(0));
        start_run(100, 1'b0);
        check_val("c_len100_busy", 32'(busy_o), 32'(1));
        for (int k = 0; k < 64; k++) do_strobe(k, 64, k == 63, (k == 63) ? 1 : 0);
        sample_en_i = 1'b0;
        tick();
        check_val("c_busy_after", 32'(busy_o), 32'(0));

        // Abort together with strobe at index 4
        start_run(8, 1'b0);
        for (int k = 0; k < 4; k++) do_strobe(k, 8, 1'b0, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_val("d_abort_valid", 32'(valid_o), 32'(0));
        check_val("d_abort_sop",   32'(sop_o),   32'(0));
        check_val("d_abort_done",  32'(done_o),  32'(0));
        check_val("d_abort_busy",  32'(busy_o),  32'(0));
        tick();
        check_val("d_idle_valid", 32'(valid_o), 32'(0));
        check_val("d_idle_done",  32'(done_o),  32'(0));
        sample_en_i = 1'b0;
        start_run(8, 1'b0);
        do_strobe(0, 8, 1'b0, 0);
        sample_en_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_val("d_abort2_busy", 32'(busy_o), 32'(0));

        // Writes during playback
        start_run(8, 1'b0);
        for (int k = 0; k < 5; k++) do_strobe(k, 8, 1'b0, 0);
        sample_en_i = 1'b0;
        wr(5, 8'hAA);
        do_strobe(5, 8, 1'b0, 0);
        wr_en_i = 1'b1; wr_addr_i = 6'd6; wr_data_i = 8'hBB;
        do_strobe(6, 8, 1'b0, 0);
        wr_en_i = 1'b0;
        exp_mem[6] = 8'hBB;
        do_strobe(7, 8, 1'b1, 1);
        sample_en_i = 1'b0;
        tick();

        // Reset mid-loop, then RAM survives
        start_run(3, 1'b1);
        for (int k = 0; k < 4; k++) do_strobe(k % 3, 3, 1'b0, (k >= 2) ? 1 : 0);
        rst_n_i = 1'b0;
        tick();
        check_val("f_rst_valid", 32'(valid_o),    32'(0));
        check_val("f_rst_data",  32'(data_o),     32'(0));
        check_val("f_rst_busy",  32'(busy_o),     32'(0));
        check_val("f_rst_pass",  32'(pass_cnt_o), 32'(0));
        check_val("f_rst_trig",  32'(trig_o),     32'(0));
        rst_n_i = 1'b1;
        sample_en_i = 1'b0;
        tick();
        check_val("f_idle_busy", 32'(busy_o), 32'(0));
        start_run(8, 1'b0);
        for (int k = 0; k < 8; k++) do_strobe(k, 8, k == 7, (k == 7) ? 1 : 0);
        sample_en_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
